// File: rtl/stage_if_pkg.sv
// ============================================================================
// Module   : stage_if_pkg
// Purpose  : Shared constants, fetch FSM encodings and field helpers for IF.
// Revision : 1.0
// ============================================================================
`default_nettype none

package stage_if_pkg;

    localparam logic [31:0] c_nop_inst = 32'h0000_0013;
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    localparam logic [1:0] c_st_issue   = 2'd0;
    localparam logic [1:0] c_st_wait    = 2'd1;
    localparam logic [1:0] c_st_discard = 2'd2;
    localparam logic [1:0] c_st_hold    = 2'd3;

    localparam int c_rs1_lsb = 15;
    localparam int c_rs2_lsb = 20;

endpackage

`default_nettype wire

// File: rtl/stage_if_id_reg.sv
// ============================================================================
// Module   : stage_if_id_reg
// Purpose  : IF/ID pipeline register: reset > flush > stall > load > bubble.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stage_if_id_reg
    import stage_if_pkg::*;
#(
    parameter int PC_WIDTH       = 32,
    parameter int INST_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush,
    input  logic                      i_stall,
    input  logic                      i_load,
    input  logic [PC_WIDTH-1:0]       i_load_pc,
    input  logic [INST_WIDTH-1:0]     i_load_inst,
    output logic [PC_WIDTH-1:0]       o_pc,
    output logic [INST_WIDTH-1:0]     o_inst,
    output logic [REG_ADDR_WIDTH-1:0] o_rs1,
    output logic [REG_ADDR_WIDTH-1:0] o_rs2,
    output logic                      o_valid
);

    logic [PC_WIDTH-1:0]       r_pc;
    logic [INST_WIDTH-1:0]     r_inst;
    logic [REG_ADDR_WIDTH-1:0] r_rs1;
    logic [REG_ADDR_WIDTH-1:0] r_rs2;
    logic                      r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_inst  <= INST_WIDTH'(c_nop_inst);
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_inst  <= INST_WIDTH'(c_nop_inst);
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            if (i_load) begin
                r_pc    <= i_load_pc;
                r_inst  <= i_load_inst;
                r_rs1   <= i_load_inst[c_rs1_lsb +: REG_ADDR_WIDTH];
                r_rs2   <= i_load_inst[c_rs2_lsb +: REG_ADDR_WIDTH];
                r_valid <= 1'b1;
            end else begin
                // Bubble: PC keeps its last value, only the payload is cleared
                r_inst  <= INST_WIDTH'(c_nop_inst);
                r_rs1   <= '0;
                r_rs2   <= '0;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_rs1   = r_rs1;
    assign o_rs2   = r_rs2;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/stage_if.sv
// ============================================================================
// Module   : stage_if
// Purpose  : Instruction fetch: PC, one-outstanding IMEM requests, stall
//            buffer and branch redirect, feeding the IF/ID register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stage_if
    import stage_if_pkg::*;
#(
    parameter int                 PC_WIDTH       = 32,
    parameter int                 INST_WIDTH     = 32,
    parameter int                 REG_ADDR_WIDTH = 5,
    parameter logic [PC_WIDTH-1:0] RESET_PC      = PC_WIDTH'(c_reset_pc)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      pc_sel,
    input  logic [PC_WIDTH-1:0]       pc_imm,
    output logic                      imem_req,
    output logic [PC_WIDTH-1:0]       imem_addr,
    input  logic                      imem_rvalid,
    input  logic [INST_WIDTH-1:0]     imem_rdata,
    output logic [PC_WIDTH-1:0]       IF_ID_pc,
    output logic [INST_WIDTH-1:0]     IF_ID_inst,
    output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    output logic                      IF_ID_valid
);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   w_pc_nxt;
    logic [PC_WIDTH-1:0]   r_req_pc;
    logic [PC_WIDTH-1:0]   r_buf_pc;
    logic [INST_WIDTH-1:0] r_buf_inst;
    logic                  w_issue;
    logic                  w_buf_capture;
    logic                  w_load;
    logic [PC_WIDTH-1:0]   w_load_pc;
    logic [INST_WIDTH-1:0] w_load_inst;

    // The stall buffer is occupied exactly while in HOLD, so it needs no flag.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_issue       = 1'b0;
        w_buf_capture = 1'b0;
        w_load        = 1'b0;
        w_load_pc     = r_req_pc;
        w_load_inst   = imem_rdata;
        case (r_state)
            c_st_issue: begin
                if (pc_sel) begin
                    w_pc_nxt = pc_imm;
                end else if (!stall) begin
                    w_issue     = 1'b1;
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (pc_sel) begin
                    w_pc_nxt    = pc_imm;
                    w_state_nxt = imem_rvalid ? c_st_issue : c_st_discard;
                end else if (imem_rvalid) begin
                    if (stall) begin
                        w_buf_capture = 1'b1;
                        w_state_nxt   = c_st_hold;
                    end else begin
                        w_load  = 1'b1;
                        w_issue = 1'b1;
                    end
                end
            end
            c_st_discard: begin
                if (pc_sel) begin
                    w_pc_nxt = pc_imm;
                end
                if (imem_rvalid) begin
                    w_state_nxt = c_st_issue;
                end
            end
            c_st_hold: begin
                if (pc_sel) begin
                    w_pc_nxt    = pc_imm;
                    w_state_nxt = c_st_issue;
                end else if (!stall) begin
                    w_load      = 1'b1;
                    w_load_pc   = r_buf_pc;
                    w_load_inst = r_buf_inst;
                    w_state_nxt = c_st_issue;
                end
            end
            default: w_state_nxt = c_st_issue;
        endcase
        if (w_issue) begin
            w_pc_nxt = r_pc + PC_WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_issue;
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_buf_pc   <= '0;
            r_buf_inst <= INST_WIDTH'(c_nop_inst);
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_issue) begin
                r_req_pc <= r_pc;
            end
            if (w_buf_capture) begin
                r_buf_pc   <= r_req_pc;
                r_buf_inst <= imem_rdata;
            end
        end
    end

    assign imem_req  = w_issue & ~reset;
    assign imem_addr = r_pc;

    stage_if_id_reg #(
        .PC_WIDTH       (PC_WIDTH),
        .INST_WIDTH     (INST_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (reset),
        .i_flush     (pc_sel),
        .i_stall     (stall),
        .i_load      (w_load),
        .i_load_pc   (w_load_pc),
        .i_load_inst (w_load_inst),
        .o_pc        (IF_ID_pc),
        .o_inst      (IF_ID_inst),
        .o_rs1       (IF_ID_rs1),
        .o_rs2       (IF_ID_rs2),
        .o_valid     (IF_ID_valid)
    );

endmodule

`default_nettype wire
